// File: rtl/pwm_multi_if.sv
// Register-decoder side of the multi-channel PWM: configuration strobes in,
// PWM outputs and period-start pulse out.
interface pwm_multi_if #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned CHANNELS  = 4,
    parameter int unsigned PRE_WIDTH = 8
);
    localparam int unsigned CHAN_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic [CHANNELS-1:0]  pwm;
    logic                 enable;
    logic                 center;
    logic [CHAN_W-1:0]    chan;
    logic [WIDTH-1:0]     level;
    logic                 set_level;
    logic [WIDTH-1:0]     period;
    logic                 set_period;
    logic [PRE_WIDTH-1:0] prescale;
    logic                 set_prescale;
    logic                 period_start;

    modport master (
        output enable, center, chan, level, set_level,
               period, set_period, prescale, set_prescale,
        input  pwm, period_start
    );

    modport slave (
        input  enable, center, chan, level, set_level,
               period, set_period, prescale, set_prescale,
        output pwm, period_start
    );
endinterface

// File: rtl/pwm_multi.sv
// Multi-channel PWM with shared prescaled period counter and double-buffered
// period/levels. Optional macro PWM_CENTER_EN adds center-aligned (triangle) counting.
module pwm_multi #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned CHANNELS  = 4,
    parameter int unsigned PRE_WIDTH = 8
) (
    input  logic         clk,
    input  logic         rstn,
    pwm_multi_if.slave   bus
);
    localparam logic [WIDTH-1:0] PERIOD_RST = {{(WIDTH-1){1'b1}}, 1'b0};

    logic [PRE_WIDTH-1:0] pre_cnt, pre_cnt_nxt, prescale_q;
    logic [WIDTH-1:0]     count, count_nxt;
    logic [WIDTH-1:0]     shadow_period, active_period;
    logic [WIDTH-1:0]     shadow_level [CHANNELS];
    logic [WIDTH-1:0]     active_level [CHANNELS];
    logic [CHANNELS-1:0]  pwm_q;
    logic                 period_start_q;
    logic                 en_q;
    logic                 tick;
    logic                 boundary;
    logic                 chan_ok;

`ifdef PWM_CENTER_EN
    typedef enum logic {DIR_UP, DIR_DOWN} dir_e;
    dir_e dir_q, dir_nxt;
    logic center_q;
`else
    logic unused_center;
    assign unused_center = bus.center;
`endif

    assign chan_ok = (32'(bus.chan) < CHANNELS);

    // Next prescaler/counter state; boundary marks the tick that ends a period
    always_comb begin
        tick        = bus.enable && (pre_cnt == prescale_q);
        pre_cnt_nxt = pre_cnt + PRE_WIDTH'(1);
        count_nxt   = count;
        boundary    = 1'b0;
`ifdef PWM_CENTER_EN
        dir_nxt     = dir_q;
`endif
        if (!bus.enable || bus.set_prescale || (pre_cnt == prescale_q)) begin
            pre_cnt_nxt = '0;
        end
        if (!bus.enable) begin
            count_nxt = '0;
`ifdef PWM_CENTER_EN
            dir_nxt   = DIR_UP;
`endif
        end else if (tick) begin
            if (count == active_period) begin
                count_nxt = '0;
                boundary  = 1'b1;
            end else begin
                count_nxt = count + WIDTH'(1);
            end
`ifdef PWM_CENTER_EN
            // Triangle: turn at the top, commit only when landing on 0 going up
            if (center_q) begin
                boundary = 1'b0;
                if (dir_q == DIR_UP) begin
                    if (count != active_period) begin
                        count_nxt = count + WIDTH'(1);
                    end else if (active_period == '0) begin
                        count_nxt = '0;
                        boundary  = 1'b1;
                    end else begin
                        count_nxt = count - WIDTH'(1);
                        dir_nxt   = DIR_DOWN;
                    end
                end else if (count <= WIDTH'(1)) begin
                    count_nxt = '0;
                    dir_nxt   = DIR_UP;
                    boundary  = 1'b1;
                end else begin
                    count_nxt = count - WIDTH'(1);
                end
            end
`endif
        end
    end

    // State, buffers and registered outputs
    always_ff @(posedge clk) begin
        if (!rstn) begin
            pre_cnt        <= '0;
            prescale_q     <= '0;
            count          <= '0;
            shadow_period  <= PERIOD_RST;
            active_period  <= PERIOD_RST;
            pwm_q          <= '0;
            period_start_q <= 1'b0;
            en_q           <= 1'b0;
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                shadow_level[i] <= '0;
                active_level[i] <= '0;
            end
`ifdef PWM_CENTER_EN
            dir_q          <= DIR_UP;
            center_q       <= 1'b0;
`endif
        end else begin
            pre_cnt        <= pre_cnt_nxt;
            count          <= count_nxt;
            en_q           <= bus.enable;
            period_start_q <= boundary || (bus.enable && !en_q);
            if (bus.set_prescale) prescale_q <= bus.prescale;
            if (bus.set_period)   shadow_period <= bus.period;
            if (bus.set_level && chan_ok) shadow_level[bus.chan] <= bus.level;
            // Active copies old shadow values, so a coincident write lands next period
            if (!bus.enable || boundary) begin
                active_period <= shadow_period;
                active_level  <= shadow_level;
            end
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                pwm_q[i] <= bus.enable && (count < active_level[i]);
            end
`ifdef PWM_CENTER_EN
            dir_q <= dir_nxt;
            if (!bus.enable || boundary) center_q <= bus.center;
`endif
        end
    end

    assign bus.pwm          = pwm_q;
    assign bus.period_start = period_start_q;
endmodule

// File: tb/tb_pwm_multi.sv
// Directed bench for pwm_multi: expected per-cycle outputs are pushed to a
// scoreboard queue as each cycle is driven and popped after the clock edge.
module tb_pwm_multi;
    localparam int unsigned WIDTH     = 8;
    localparam int unsigned CHANNELS  = 5;
    localparam int unsigned PRE_WIDTH = 8;
    localparam int unsigned CHAN_W    = $clog2(CHANNELS);

    typedef struct packed {
        logic [CHANNELS-1:0] pwm;
        logic                ps;
    } exp_t;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    pwm_multi_if #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .PRE_WIDTH(PRE_WIDTH)) bus ();

    pwm_multi #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .PRE_WIDTH(PRE_WIDTH)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   lv [CHANNELS];

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check_one(input string tag);
        exp_t e;
        e = sb.pop_front();
        vectors++;
        assert (bus.pwm === e.pwm) else begin
            miscompares++;
            $error("FAIL %s pwm observed %b expected %b", tag, bus.pwm, e.pwm);
        end
        vectors++;
        assert (bus.period_start === e.ps) else begin
            miscompares++;
            $error("FAIL %s period_start observed %b expected %b", tag, bus.period_start, e.ps);
        end
    endtask

    // One cycle where both outputs must be low (disabled or in reset)
    task automatic quiet_cyc(input string tag);
        sb.push_back('0);
        cyc();
        check_one(tag);
    endtask

    // Edge mode from an enable rise at cycle 0: count(n) = (n/(s+1)) mod (p+1)
    function automatic exp_t edge_exp(input int n, input int p, input int s);
        exp_t e;
        int   cnt;
        cnt  = (n / (s + 1)) % (p + 1);
        for (int i = 0; i < CHANNELS; i++) e.pwm[i] = (cnt < lv[i]);
        e.ps = (n == 0) || (((n + 1) % ((p + 1) * (s + 1))) == 0);
        return e;
    endfunction

    task automatic run_edge(input int ncyc, input int p, input int s, input string tag);
        for (int n = 0; n < ncyc; n++) begin
            sb.push_back(edge_exp(n, p, s));
            cyc();
            check_one(tag);
        end
    endtask

    task automatic wr_level(input int c, input int v, input string tag);
        bus.chan      = CHAN_W'(c);
        bus.level     = WIDTH'(v);
        bus.set_level = 1'b1;
        quiet_cyc(tag);
        bus.set_level = 1'b0;
    endtask

    initial begin
        rstn             = 1'b0;
        bus.enable       = 1'b0;
        bus.center       = 1'b0;
        bus.chan         = '0;
        bus.level        = '0;
        bus.set_level    = 1'b0;
        bus.period       = '0;
        bus.set_period   = 1'b0;
        bus.prescale     = '0;
        bus.set_prescale = 1'b0;
        for (int i = 0; i < CHANNELS; i++) lv[i] = 0;
        cyc();
        quiet_cyc("reset");
        rstn = 1'b1;

        // Default period 254, prescale 0: ch0 128/255, ch1 off, ch2 always on
        wr_level(0, 8'h80, "t1_dis");
        wr_level(2, 8'hFF, "t1_dis");
        lv[0] = 8'h80;
        lv[2] = 8'hFF;
        quiet_cyc("t1_dis");
        bus.enable = 1'b1;
        run_edge(520, 254, 0, "t1_default");

        // period 9, prescale 3, ch0 level 5, all strobes in one cycle
        bus.enable       = 1'b0;
        bus.period       = 8'd9;
        bus.set_period   = 1'b1;
        bus.prescale     = 8'd3;
        bus.set_prescale = 1'b1;
        bus.chan         = '0;
        bus.level        = 8'd5;
        bus.set_level    = 1'b1;
        quiet_cyc("t2_dis");
        bus.set_period   = 1'b0;
        bus.set_prescale = 1'b0;
        bus.set_level    = 1'b0;
        lv[0] = 5;
        quiet_cyc("t2_dis");
        quiet_cyc("t2_dis");
        bus.enable = 1'b1;
        run_edge(100, 9, 3, "t2_presc");

        // Mid-period level write, then a write in the boundary cycle
        bus.enable       = 1'b0;
        bus.prescale     = '0;
        bus.set_prescale = 1'b1;
        quiet_cyc("t3_dis");
        bus.set_prescale = 1'b0;
        quiet_cyc("t3_dis");
        bus.enable = 1'b1;
        bus.chan   = '0;
        for (int n = 0; n < 50; n++) begin
            bus.set_level = (n == 3) || (n == 19);
            bus.level     = (n == 3) ? 8'd2 : 8'd7;
            lv[0]         = (n < 10) ? 5 : (n < 30) ? 2 : 7;
            sb.push_back(edge_exp(n, 9, 0));
            cyc();
            check_one("t3_shadow");
        end
        bus.set_level = 1'b0;

        // Writes while disabled, out-of-range channel ignored, last channel valid
        bus.enable = 1'b0;
        quiet_cyc("t4_dis");
        wr_level(3, 7, "t4_dis");
        wr_level(5, 8'hAA, "t4_dis");
        wr_level(4, 10, "t4_dis");
        lv[3] = 7;
        lv[4] = 10;
        quiet_cyc("t4_dis");
        bus.enable = 1'b1;
        run_edge(33, 9, 0, "t4_enable");

        // Reset mid-period with enable held high
        rstn = 1'b0;
        quiet_cyc("t5_rst");
        quiet_cyc("t5_rst");
        rstn = 1'b1;
        for (int i = 0; i < CHANNELS; i++) lv[i] = 0;
        run_edge(300, 254, 0, "t5_after_rst");

`ifdef PWM_CENTER_EN
        // Center-aligned: period 4 gives count 0,1,2,3,4,3,2,1
        bus.enable     = 1'b0;
        bus.center     = 1'b1;
        bus.period     = 8'd4;
        bus.set_period = 1'b1;
        quiet_cyc("t6_dis");
        bus.set_period = 1'b0;
        wr_level(0, 2, "t6_dis");
        quiet_cyc("t6_dis");
        bus.enable = 1'b1;
        for (int n = 0; n < 40; n++) begin
            exp_t e;
            int   idx;
            int   cnt;
            idx   = n % 8;
            cnt   = (idx <= 4) ? idx : 8 - idx;
            e.pwm = '0;
            e.pwm[0] = (cnt < 2);
            e.ps  = (n == 0) || (((n + 1) % 8) == 0);
            sb.push_back(e);
            cyc();
            check_one("t6_center");
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/pwm_multi.md
Name: pwm_multi

Overview:
Multi-channel, parametrised PWM generator; next generation of the team's single 8-bit PWM peripheral. Shared period counter with programmable period and clock prescaler; per-channel duty levels, double-buffered and committed at period boundaries so outputs never glitch mid-period. Sits on the peripheral bus behind the register decoder, which drives the set_* strobes.

Parameters:
WIDTH, 8, width of counter, period and level values
CHANNELS, 4, number of PWM outputs (1..16)
PRE_WIDTH, 8, width of prescaler reload value

Ports:
clk  input  1  clock
rstn  input  1  reset, synchronous, active-low
pwm  output  CHANNELS  PWM outputs, registered
enable  input  1  1 = run; 0 = counters held at 0, outputs low
center  input  1  1 = center-aligned mode (only with PWM_CENTER_EN)
chan  input  max(1,$clog2(CHANNELS))  channel index for set_level
level  input  WIDTH  duty value, sampled when set_level high
set_level  input  1  write level into shadow[chan]
period  input  WIDTH  period value, sampled when set_period high
set_period  input  1  write period into shadow period
prescale  input  PRE_WIDTH  prescaler reload, sampled when set_prescale high
set_prescale  input  1  write prescale (takes effect immediately)
period_start  output  1  one-cycle pulse when a new period begins (registered)

Behaviour:
- Reset: count=0, prescaler count=0, prescale=0, active/shadow period = 2^WIDTH-2, all active/shadow levels=0, pwm=0, period_start=0, direction=up.
- Prescaler: counts 0..prescale; tick asserted in the cycle it equals prescale, then wraps to 0. prescale=0 -> tick every cycle. Writing prescale resets prescaler count to 0.
- Edge mode: on tick, count increments; when count==active_period, count wraps to 0 (the "boundary"). Period length = (active_period+1)*(prescale+1) clocks.
- Boundary: active_period <= shadow_period, active_level[i] <= shadow_level[i] for all i; period_start pulses next cycle.
- Compare: pwm[i] registered as enable && (count < active_level[i]); one-clock latency from count. Level 0 = always low; level > active_period = always high (default period: level 2^WIDTH-1 = always on).
- set_level/set_period coincident with boundary: shadow written, active takes OLD shadow; new value applies from following period. Out-of-range chan (>= CHANNELS): write ignored.
- Multiple set_* strobes same cycle: all honoured independently.
- enable=0: count, prescaler, direction held at reset values; pwm=0; active <= shadow every cycle (writes visible on first period after enable). enable rising: first period starts with count=0, period_start pulses one cycle later.
- Period change to a value below current count: no effect until boundary (active only updates at boundary).
- Reset mid-period: all state returns to reset values next edge; no partial period output.

Optional Feature:
PWM_CENTER_EN: when defined and center=1, count is a triangle: up 0..active_period, then down to 0; direction flips at each end (each endpoint value held for one tick). Boundary (shadow commit, period_start) only at count==0 when turning up. Period = 2*active_period ticks. Compare rule unchanged, giving symmetric pulses. center sampled only at boundary or while disabled. Without macro: center ignored, edge mode only, no direction register synthesised.

Test Plan:
Default period, prescale=0, ch0 level=0x80, ch1=0, ch2=0xFF -> ch0 high 128 of every 255 clocks, ch1 constant 0, ch2 constant 1; period_start every 255 clocks.
period=9, prescale=3, ch0 level=5 -> period 40 clocks, ch0 high 20 clocks, period_start every 40.
Mid-period set_level ch0 5->2 at count=3 -> current period unchanged, next period high 2 ticks; write in boundary cycle applies one period later.
enable=0 with set_level ch3=7, then enable=1 -> pwm=0 while disabled; first enabled period ch3 high 7 ticks; chan=5 write with CHANNELS=4 -> no change.
rstn low mid-period with levels set -> pwm=0, period_start=0, levels 0, period 2^WIDTH-2 after release.
PWM_CENTER_EN, center=1, period=4, level=2 -> count 0,1,2,3,4,3,2,1 repeating; pwm high during counts 0,1 (both slopes), period_start every 8 clocks.
